// File: rtl/toggle_monitor_pkg.sv
// -----------------------------------------------------------------------------
// toggle_monitor_pkg
//   Shared definitions for the toggle monitor and for the upstream toggler
//   bench: the monitor state encoding and the default parameter values.
// -----------------------------------------------------------------------------
package toggle_monitor_pkg;

  localparam int DEF_TOGGLE_PERIOD = 5;   // expected cycles between edges (>= 2)
  localparam int DEF_TOLERANCE     = 0;   // allowed +/- deviation in cycles
  localparam int DEF_LOCK_COUNT    = 4;   // in-tolerance intervals needed to lock (>= 1)
  localparam int DEF_CNT_WIDTH     = 16;  // interval counter / period width (<= 31)

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_FAULT   = 2'd3
  } state_t;

endpackage

// File: rtl/toggle_monitor_edge.sv
// -----------------------------------------------------------------------------
// toggle_edge_detect
//   Registers the incoming toggle once and flags a transition whenever the
//   live input differs from its registered copy.
//
// Ports
//   i_clk      : clock, rising edge
//   i_rst      : synchronous active-high reset (registered copy -> 0)
//   i_toggle   : toggle input, synchronous to i_clk
//   o_edge_det : combinational, high in the cycle a transition is seen
// -----------------------------------------------------------------------------
module toggle_edge_detect (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_toggle,
  output logic o_edge_det
);

  logic r_toggle;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_toggle <= 1'b0;
    else       r_toggle <= i_toggle;
  end

  assign o_edge_det = i_toggle ^ r_toggle;

endmodule

// File: rtl/toggle_monitor.sv
// -----------------------------------------------------------------------------
// toggle_monitor
//   Measures the interval between toggle transitions, locks onto a stream of
//   in-tolerance intervals and raises a sticky fault when a locked stream
//   drifts or stops.
//
// Handshake: there is no backpressure. o_edge and o_period_valid are
//   single-cycle strobes; o_period is meaningful in the cycle o_period_valid
//   is high and holds its value until the next update.
//
// Ports
//   i_clk          : clock, rising edge
//   i_rst          : synchronous active-high reset
//   i_toggle       : square wave from the upstream toggler
//   i_clear        : one-cycle pulse, returns to IDLE from any state
//   o_edge         : one-cycle pulse per detected transition
//   o_period       : last measured interval in cycles
//   o_period_valid : one-cycle pulse when o_period updates
//   o_edge_count   : detected edge count, wraps 255 -> 0
//   o_locked       : high while LOCKED
//   o_fault        : high while FAULT
//   o_state        : current FSM state (debug)
// -----------------------------------------------------------------------------
module toggle_monitor
  import toggle_monitor_pkg::*;
#(
  parameter int TOGGLE_PERIOD = DEF_TOGGLE_PERIOD,
  parameter int TOLERANCE     = DEF_TOLERANCE,
  parameter int LOCK_COUNT    = DEF_LOCK_COUNT,
  parameter int CNT_WIDTH     = DEF_CNT_WIDTH
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_toggle,
  input  logic                 i_clear,
  output logic                 o_edge,
  output logic [CNT_WIDTH-1:0] o_period,
  output logic                 o_period_valid,
  output logic [7:0]           o_edge_count,
  output logic                 o_locked,
  output logic                 o_fault,
  output state_t               o_state
);

  localparam int MW = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam int HI = TOGGLE_PERIOD + TOLERANCE;
  localparam int LO = TOGGLE_PERIOD - TOLERANCE;

  logic                 w_edge_det;
  logic                 w_in_tol;
  logic                 w_timeout;
  int                   w_cnt_int;
  state_t               r_state, w_state_nxt;
  logic [MW-1:0]        r_match, w_match_nxt;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_edge;
  logic [CNT_WIDTH-1:0] r_period;
  logic                 r_period_valid;
  logic [7:0]           r_edge_count;
  logic                 r_locked;
  logic                 r_fault;

  toggle_edge_detect u_edge (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_toggle   (i_toggle),
    .o_edge_det (w_edge_det)
  );

  // r_cnt holds the cycles elapsed since the last edge, i.e. the interval
  // being closed when an edge arrives. Compared as a signed int so a
  // negative lower bound (TOLERANCE > TOGGLE_PERIOD) behaves sensibly.
  always_comb begin
    w_cnt_int = int'(r_cnt);
    w_in_tol  = (w_cnt_int >= LO) && (w_cnt_int <= HI);
    w_timeout = !w_edge_det && (w_cnt_int > HI);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_match_nxt = r_match;
    case (r_state)
      ST_IDLE: begin
        if (w_edge_det) begin
          w_state_nxt = ST_ACQUIRE;
          w_match_nxt = '0;
        end
      end
      ST_ACQUIRE: begin
        if (w_edge_det) begin
          if (w_in_tol) begin
            if (r_match == MW'(LOCK_COUNT - 1)) w_state_nxt = ST_LOCKED;
            else                                w_match_nxt = r_match + MW'(1);
          end else begin
            w_match_nxt = '0;
          end
        end else if (w_timeout) begin
          w_state_nxt = ST_IDLE;
          w_match_nxt = '0;
        end
      end
      ST_LOCKED: begin
        if ((w_edge_det && !w_in_tol) || w_timeout) w_state_nxt = ST_FAULT;
      end
      ST_FAULT: begin
        w_state_nxt = ST_FAULT;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_match_nxt = '0;
      end
    endcase
    // Clear overrides whatever the edge/timeout logic decided.
    if (i_clear) begin
      w_state_nxt = ST_IDLE;
      w_match_nxt = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= ST_IDLE;
      r_match        <= '0;
      r_cnt          <= '0;
      r_edge         <= 1'b0;
      r_period       <= '0;
      r_period_valid <= 1'b0;
      r_edge_count   <= '0;
      r_locked       <= 1'b0;
      r_fault        <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_match <= w_match_nxt;

      if (i_clear)         r_cnt <= '0;
      else if (w_edge_det) r_cnt <= CNT_WIDTH'(1);
      else if (r_cnt != '1) r_cnt <= r_cnt + CNT_WIDTH'(1);

      // Edges are counted even when a clear swallows them.
      r_edge <= w_edge_det;
      if (w_edge_det) r_edge_count <= r_edge_count + 8'd1;

      // The first edge seen from IDLE opens a measurement; it closes none.
      r_period_valid <= 1'b0;
      if (w_edge_det && !i_clear && (r_state != ST_IDLE)) begin
        r_period       <= r_cnt;
        r_period_valid <= 1'b1;
      end

      r_locked <= (w_state_nxt == ST_LOCKED);
      r_fault  <= (w_state_nxt == ST_FAULT);
    end
  end

  assign o_edge         = r_edge;
  assign o_period       = r_period;
  assign o_period_valid = r_period_valid;
  assign o_edge_count   = r_edge_count;
  assign o_locked       = r_locked;
  assign o_fault        = r_fault;
  assign o_state        = r_state;

endmodule

// File: tb/tb_toggle_monitor.sv
// -----------------------------------------------------------------------------
// tb_toggle_monitor
//   Three monitor instances: u0 defaults, u1 TOLERANCE=1, u2 CNT_WIDTH=4.
//   A timestamp-based reference model predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_toggle_monitor;
  import toggle_monitor_pkg::*;

  localparam int M_IDLE = 0, M_ACQ = 1, M_LOCK = 2, M_FAULT = 3;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rs[3], tg[3], cl[3];
  logic oe[3], opv[3], olk[3], oft[3];
  logic [7:0]  oec[3];
  logic [15:0] per0, per1;
  logic [3:0]  per2;
  state_t      st[3];

  toggle_monitor u0 (
    .i_clk(clk), .i_rst(rs[0]), .i_toggle(tg[0]), .i_clear(cl[0]),
    .o_edge(oe[0]), .o_period(per0), .o_period_valid(opv[0]),
    .o_edge_count(oec[0]), .o_locked(olk[0]), .o_fault(oft[0]), .o_state(st[0]));

  toggle_monitor #(.TOLERANCE(1)) u1 (
    .i_clk(clk), .i_rst(rs[1]), .i_toggle(tg[1]), .i_clear(cl[1]),
    .o_edge(oe[1]), .o_period(per1), .o_period_valid(opv[1]),
    .o_edge_count(oec[1]), .o_locked(olk[1]), .o_fault(oft[1]), .o_state(st[1]));

  toggle_monitor #(.CNT_WIDTH(4)) u2 (
    .i_clk(clk), .i_rst(rs[2]), .i_toggle(tg[2]), .i_clear(cl[2]),
    .o_edge(oe[2]), .o_period(per2), .o_period_valid(opv[2]),
    .o_edge_count(oec[2]), .o_locked(olk[2]), .o_fault(oft[2]), .o_state(st[2]));

  // reference model parameters and state
  int PP[3]   = '{5, 5, 5};
  int TT[3]   = '{0, 1, 0};
  int LL[3]   = '{4, 4, 4};
  int MAXC[3] = '{65535, 65535, 15};

  int   n;                 // posedge index
  int   anchor[3];         // interval counter reads min(n - anchor, MAXC)
  int   mode[3];
  int   streak[3];
  logic prev[3];
  logic e_edge[3], e_pv[3];
  int   e_per[3], e_ec[3];

  // scoreboard of checks
  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] get_per(int i);
    case (i)
      0:       return 32'(per0);
      1:       return 32'(per1);
      default: return 32'(per2);
    endcase
  endfunction

  function automatic state_t exp_state(int m);
    case (m)
      M_ACQ:   return ST_ACQUIRE;
      M_LOCK:  return ST_LOCKED;
      M_FAULT: return ST_FAULT;
      default: return ST_IDLE;
    endcase
  endfunction

  task automatic chk(string tag, int i, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s u%0d cycle %0d: got %0d expected %0d", tag, i, n, obs, exp);
    end
  endtask

  task automatic model_step(int i);
    bit ev, ok, late;
    int since, dev;
    if (rs[i]) begin
      prev[i] = 1'b0; anchor[i] = n + 1; mode[i] = M_IDLE; streak[i] = 0;
      e_edge[i] = 0; e_pv[i] = 0; e_per[i] = 0; e_ec[i] = 0;
      return;
    end
    ev      = (tg[i] !== prev[i]);
    prev[i] = tg[i];
    since   = n - anchor[i];
    if (since > MAXC[i]) since = MAXC[i];
    dev  = since - PP[i];
    if (dev < 0) dev = -dev;
    ok   = (dev <= TT[i]);
    late = (since > PP[i] + TT[i]);
    e_edge[i] = ev;
    if (ev) e_ec[i] = (e_ec[i] + 1) % 256;
    e_pv[i] = 0;
    if (cl[i]) begin
      mode[i] = M_IDLE; streak[i] = 0; anchor[i] = n + 1;
    end else begin
      if (ev && mode[i] != M_IDLE) begin
        e_per[i] = since; e_pv[i] = 1;
      end
      case (mode[i])
        M_IDLE: if (ev) begin mode[i] = M_ACQ; streak[i] = 0; end
        M_ACQ: begin
          if (ev) begin
            if (ok) begin
              streak[i]++;
              if (streak[i] >= LL[i]) mode[i] = M_LOCK;
            end else streak[i] = 0;
          end else if (late) begin
            mode[i] = M_IDLE; streak[i] = 0;
          end
        end
        M_LOCK: if ((ev && !ok) || (!ev && late)) mode[i] = M_FAULT;
        default: ;
      endcase
      if (ev) anchor[i] = n;
    end
  endtask

  task automatic check_all(int i);
    chk("edge",         i, 32'(oe[i]),  32'(e_edge[i]));
    chk("period_valid", i, 32'(opv[i]), 32'(e_pv[i]));
    chk("period",       i, get_per(i),  32'(e_per[i]));
    chk("edge_count",   i, 32'(oec[i]), 32'(e_ec[i]));
    chk("locked",       i, 32'(olk[i]), 32'(mode[i] == M_LOCK));
    chk("fault",        i, 32'(oft[i]), 32'(mode[i] == M_FAULT));
    chk("state",        i, 32'(st[i]),  32'(exp_state(mode[i])));
  endtask

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    n++;
    for (int i = 0; i < 3; i++) model_step(i);
    #1;
    for (int i = 0; i < 3; i++) check_all(i);
  endtask

  task automatic half(int i, int len);
    tg[i] = ~tg[i];
    repeat (len) cyc();
  endtask

  int cdown[3];

  initial begin
    n = 0;
    for (int i = 0; i < 3; i++) begin
      rs[i] = 1'b1; tg[i] = 1'b0; cl[i] = 1'b0;
      prev[i] = 1'b0; anchor[i] = 0; mode[i] = M_IDLE; streak[i] = 0;
      e_edge[i] = 0; e_pv[i] = 0; e_per[i] = 0; e_ec[i] = 0;
    end
    cyc(); cyc();
    for (int i = 0; i < 3; i++) rs[i] = 1'b0;
    chk("reset_period", 0, 32'(per0), 0);
    chk("reset_edge_count", 0, 32'(oec[0]), 0);
    chk("reset_locked", 0, 32'(olk[0]), 0);

    // u0: steady toggling locks after the 5th edge
    repeat (6) half(0, 5);
    chk("steady_locked", 0, 32'(olk[0]), 1);
    chk("steady_period", 0, 32'(per0), 5);

    // u0: one stretched half-period faults, period reads 7
    half(0, 7);
    tg[0] = ~tg[0]; cyc();
    chk("stretch_period", 0, 32'(per0), 7);
    chk("stretch_fault", 0, 32'(oft[0]), 1);
    chk("stretch_locked", 0, 32'(olk[0]), 0);
    repeat (4) cyc();

    // u0: clear coinciding with an edge, then relock
    tg[0] = ~tg[0]; cl[0] = 1'b1; cyc(); cl[0] = 1'b0;
    repeat (4) cyc();
    repeat (6) half(0, 5);
    chk("relock_locked", 0, 32'(olk[0]), 1);

    // u0: toggle stops while locked -> fault
    repeat (10) cyc();
    chk("stall_fault", 0, 32'(oft[0]), 1);

    // u0: long steady run wraps edge_count
    cl[0] = 1'b1; cyc(); cl[0] = 1'b0;
    repeat (280) half(0, 5);
    chk("wrap_locked", 0, 32'(olk[0]), 1);

    // u0: reset while locked
    rs[0] = 1'b1; cyc(); rs[0] = 1'b0;
    chk("rst_locked", 0, 32'(olk[0]), 0);
    chk("rst_edge_count", 0, 32'(oec[0]), 0);
    chk("rst_period", 0, 32'(per0), 0);

    // u1: intervals 4,6,5,4 lock with TOLERANCE=1
    half(1, 4); half(1, 6); half(1, 5); half(1, 4); half(1, 5);
    chk("tol_locked", 1, 32'(olk[1]), 1);
    cl[1] = 1'b1; cyc(); cl[1] = 1'b0;
    half(1, 5); half(1, 3); half(1, 5); half(1, 5); half(1, 5); half(1, 5);
    chk("tol_delayed", 1, 32'(olk[1]), 0);
    half(1, 5);
    chk("tol_relocked", 1, 32'(olk[1]), 1);

    // u2: CNT_WIDTH=4, reset while locked, then idle saturation
    repeat (6) half(2, 5);
    chk("w4_locked", 2, 32'(olk[2]), 1);
    rs[2] = 1'b1; cyc(); rs[2] = 1'b0;
    repeat (30) cyc();
    chk("w4_idle_fault", 2, 32'(oft[2]), 0);
    chk("w4_idle_period", 2, 32'(per2), 0);
    repeat (6) half(2, 5);
    repeat (30) cyc();
    tg[2] = ~tg[2]; cyc();
    chk("w4_sat_period", 2, 32'(per2), 15);

    // randomized toggling with occasional clear and reset on all instances
    for (int i = 0; i < 3; i++) cdown[i] = $urandom_range(3, 7);
    repeat (900) begin
      for (int i = 0; i < 3; i++) begin
        cl[i] = ($urandom_range(0, 59) == 0);
        rs[i] = ($urandom_range(0, 299) == 0);
        cdown[i]--;
        if (cdown[i] <= 0) begin
          tg[i] = ~tg[i];
          cdown[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(3, 9) : $urandom_range(4, 6);
        end
      end
      cyc();
    end
    for (int i = 0; i < 3; i++) begin cl[i] = 1'b0; rs[i] = 1'b0; end
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
